// File: rtl/execute_unit.sv
// Execute stage: single-cycle ALU, branch/jump resolution, and a 16-step
// iterative shift-add multiplier that back-pressures the decoder.
module execute_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic [3:0]  opcode,
    input  logic [2:0]  dest_num,
    input  logic [15:0] left_in,
    input  logic [15:0] right_in,
    input  logic [15:0] imm_in,
    input  logic [2:0]  cond_mask,
    input  logic [15:0] pc_in,
    input  logic [2:0]  cond_bits,
    output logic [2:0]  write_register_num,
    output logic [15:0] write_register_in,
    output logic        write_en,
    output logic [15:0] pc_register_in,
    output logic        pc_write_en,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_MOVI = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_BR   = 4'd9;
    localparam logic [3:0] OP_JMP  = 4'd10;

    state_t      state_r;
    logic [15:0] mcand_r;
    logic [15:0] mplier_r;
    logic [15:0] acc_r;
    logic [3:0]  step_r;
    logic [2:0]  mul_dest_r;

    logic [15:0] alu_s;
    logic [15:0] acc_next_s;
    logic        accept_s;
    logic        br_taken_s;

    assign issue_ready = (state_r == IDLE) && !rst;
    assign busy        = (state_r == MUL);
    assign accept_s    = issue_valid && issue_ready;

    // Single-cycle result and branch condition for the presented operation.
    always_comb begin
        alu_s      = 16'h0000;
        br_taken_s = ((cond_mask & cond_bits) != 3'b000);
        case (opcode)
            OP_ADD:  alu_s = left_in + right_in;
            OP_SUB:  alu_s = left_in - right_in;
            OP_AND:  alu_s = left_in & right_in;
            OP_OR:   alu_s = left_in | right_in;
            OP_XOR:  alu_s = left_in ^ right_in;
            OP_SHL:  alu_s = left_in << right_in[3:0];
            OP_SHR:  alu_s = left_in >> right_in[3:0];
            OP_MOVI: alu_s = imm_in;
            default: alu_s = 16'h0000;
        endcase
    end

    // One shift-add step: accumulate the multiplicand when the multiplier LSB is set.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Control FSM, multiplier datapath and registered writeback/PC strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= IDLE;
            mcand_r            <= 16'h0000;
            mplier_r           <= 16'h0000;
            acc_r              <= 16'h0000;
            step_r             <= 4'd0;
            mul_dest_r         <= 3'd0;
            write_register_num <= 3'd0;
            write_register_in  <= 16'h0000;
            write_en           <= 1'b0;
            pc_register_in     <= 16'h0000;
            pc_write_en        <= 1'b0;
        end else begin
            write_en    <= 1'b0;
            pc_write_en <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        case (opcode)
                            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
                            OP_SHL, OP_SHR, OP_MOVI: begin
                                write_register_num <= dest_num;
                                write_register_in  <= alu_s;
                                write_en           <= 1'b1;
                            end
                            OP_MUL: begin
                                mcand_r    <= left_in;
                                mplier_r   <= right_in;
                                acc_r      <= 16'h0000;
                                step_r     <= 4'd0;
                                mul_dest_r <= dest_num;
                                state_r    <= MUL;
                            end
                            OP_BR: begin
                                if (br_taken_s) begin
                                    pc_register_in <= pc_in + imm_in;
                                    pc_write_en    <= 1'b1;
                                end
                            end
                            OP_JMP: begin
                                pc_register_in <= left_in;
                                pc_write_en    <= 1'b1;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                MUL: begin
                    acc_r    <= acc_next_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    step_r   <= step_r + 4'd1;
                    // The final step's sum goes straight to the writeback register.
                    if (step_r == 4'd15) begin
                        write_register_num <= mul_dest_r;
                        write_register_in  <= acc_next_s;
                        write_en           <= 1'b1;
                        step_r             <= 4'd0;
                        state_r            <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_execute_unit.sv
// Randomized self-checking bench for execute_unit against a behavioural model.
module tb_execute_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  opcode;
    logic [2:0]  dest_num;
    logic [15:0] left_in, right_in, imm_in, pc_in;
    logic [2:0]  cond_mask, cond_bits;
    logic [2:0]  write_register_num;
    logic [15:0] write_register_in;
    logic        write_en;
    logic [15:0] pc_register_in;
    logic        pc_write_en;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic        exp_we, exp_pwe;
    logic [2:0]  exp_num;
    logic [15:0] exp_data, exp_pc;

    execute_unit dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .dest_num(dest_num),
        .left_in(left_in), .right_in(right_in), .imm_in(imm_in),
        .cond_mask(cond_mask), .pc_in(pc_in), .cond_bits(cond_bits),
        .write_register_num(write_register_num),
        .write_register_in(write_register_in), .write_en(write_en),
        .pc_register_in(pc_register_in), .pc_write_en(pc_write_en),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step_clk;
        @(posedge clk);
        #1;
    endtask

    // Behavioural result of a register-writing op, arithmetic modulo 2^16.
    function automatic logic [15:0] ref_result(input int op, input int l, input int r, input int imm);
        int sh;
        sh = r % 16;
        case (op)
            0: return 16'((l + r) % 65536);
            1: return 16'((l - r + 65536) % 65536);
            2: return 16'(l & r);
            3: return 16'(l | r);
            4: return 16'(l ^ r);
            5: return 16'((l * (1 << sh)) % 65536);
            6: return 16'(l / (1 << sh));
            7: return 16'(imm);
            8: return 16'((longint'(l) * longint'(r)) % 65536);
            default: return 16'h0000;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".we"},   write_en, exp_we);
        check_eq({tag, ".pwe"},  pc_write_en, exp_pwe);
        check_eq({tag, ".num"},  write_register_num, exp_num);
        check_eq({tag, ".data"}, write_register_in, exp_data);
        check_eq({tag, ".pc"},   pc_register_in, exp_pc);
    endtask

    task automatic set_op(input int op, input int d, input int l, input int r,
                          input int imm, input int m, input int pc, input int cb);
        opcode = 4'(op); dest_num = 3'(d); left_in = 16'(l); right_in = 16'(r);
        imm_in = 16'(imm); cond_mask = 3'(m); pc_in = 16'(pc); cond_bits = 3'(cb);
    endtask

    // Issue one non-MUL op (issue_valid left high so callers can chain back-to-back).
    task automatic do_single(input string tag, input int op, input int d, input int l, input int r,
                             input int imm, input int m, input int pc, input int cb);
        set_op(op, d, l, r, imm, m, pc, cb);
        issue_valid = 1'b1;
        check_eq({tag, ".ready"}, issue_ready, 1'b1);
        step_clk();
        exp_we  = 1'b0;
        exp_pwe = 1'b0;
        if (op <= 7) begin
            exp_we   = 1'b1;
            exp_num  = 3'(d);
            exp_data = ref_result(op, l, r, imm);
        end
        if (op == 9 && (m & cb) != 0) begin
            exp_pwe = 1'b1;
            exp_pc  = 16'((pc + imm) % 65536);
        end
        if (op == 10) begin
            exp_pwe = 1'b1;
            exp_pc  = 16'(l);
        end
        check_outputs(tag);
    endtask

    task automatic idle_cycle(input string tag);
        issue_valid = 1'b0;
        step_clk();
        exp_we  = 1'b0;
        exp_pwe = 1'b0;
        check_outputs(tag);
    endtask

    task automatic do_mul(input string tag, input int l, input int r, input int d);
        set_op(8, d, l, r, 0, 0, 0, 0);
        issue_valid = 1'b1;
        check_eq({tag, ".ready"}, issue_ready, 1'b1);
        step_clk();
        issue_valid = 1'b0;
        check_eq({tag, ".busy0"}, busy, 1'b1);
        check_eq({tag, ".ready0"}, issue_ready, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            if (i < 16) begin
                check_eq({tag, ".quiet"}, {write_en, pc_write_en, issue_ready, write_register_in},
                         {1'b0, 1'b0, 1'b0, exp_data});
            end
            step_clk();
        end
        exp_we   = 1'b1;
        exp_pwe  = 1'b0;
        exp_num  = 3'(d);
        exp_data = ref_result(8, l, r, 0);
        check_outputs(tag);
        check_eq({tag, ".busy_end"}, busy, 1'b0);
        check_eq({tag, ".ready_end"}, issue_ready, 1'b1);
        idle_cycle({tag, ".after"});
    endtask

    initial begin
        int n;
        int op;
        logic saw_we;
        rst = 1'b1;
        issue_valid = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0, 0);
        exp_we = 1'b0; exp_pwe = 1'b0; exp_num = 3'd0; exp_data = 16'h0000; exp_pc = 16'h0000;
        step_clk();
        step_clk();
        check_outputs("reset");
        check_eq("reset.ready", issue_ready, 1'b0);
        check_eq("reset.busy", busy, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("post_reset.ready", issue_ready, 1'b1);

        // Directed cases.
        do_single("add", 0, 3, 16'h7FFF, 16'h0001, 0, 0, 0, 0);
        check_eq("add.data_lit", write_register_in, 16'h8000);
        idle_cycle("add.drop");
        do_single("sub0", 1, 0, 5, 5, 0, 0, 0, 0);
        do_single("xor", 4, 2, 16'hF0F0, 16'h0FF0, 0, 0, 0, 0);
        check_eq("xor.data_lit", write_register_in, 16'hFF00);
        idle_cycle("xor.drop");
        do_mul("mul1", 16'h0123, 16'h0045, 1);
        check_eq("mul1.lit", exp_data, 16'h4E6F);
        do_mul("mul2", 16'hFFFF, 16'hFFFF, 6);
        do_single("br_t", 9, 0, 0, 0, 16'hFFF0, 3'b100, 16'h0010, 3'b100);
        idle_cycle("br_t.drop");
        do_single("br_nt", 9, 0, 0, 0, 16'hFFF0, 3'b100, 16'h0010, 3'b001);
        do_single("jmp", 10, 4, 16'h1234, 0, 0, 0, 0, 0);
        do_single("nop", 13, 7, 16'h1111, 16'h2222, 0, 0, 0, 0);
        idle_cycle("nop.drop");

        // ADD held during MUL is accepted right after the MUL writeback.
        set_op(8, 1, 3, 7, 0, 0, 0, 0);
        issue_valid = 1'b1;
        step_clk();
        set_op(0, 5, 16'h1111, 16'h2222, 0, 0, 0, 0);
        n = 0;
        while (!write_en && n < 40) begin
            step_clk();
            n++;
        end
        check_eq("hold.lat", 32'(n), 32'd16);
        check_eq("hold.mul", {write_register_num, write_register_in}, {3'd1, 16'd21});
        step_clk();
        issue_valid = 1'b0;
        exp_we = 1'b1; exp_pwe = 1'b0; exp_num = 3'd5; exp_data = 16'h3333;
        check_outputs("hold.add");
        idle_cycle("hold.drop");

        // Reset after eight MUL steps aborts without a writeback.
        set_op(8, 2, 16'h00FF, 16'h00FF, 0, 0, 0, 0);
        issue_valid = 1'b1;
        step_clk();
        issue_valid = 1'b0;
        repeat (8) step_clk();
        rst = 1'b1;
        step_clk();
        exp_we = 1'b0; exp_pwe = 1'b0; exp_num = 3'd0; exp_data = 16'h0000; exp_pc = 16'h0000;
        check_outputs("abort");
        check_eq("abort.busy", busy, 1'b0);
        check_eq("abort.ready", issue_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("abort.ready_after", issue_ready, 1'b1);
        saw_we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step_clk();
            saw_we = saw_we | write_en | busy;
        end
        check_eq("abort.no_we", saw_we, 1'b0);

        // Random mix, single-cycle ops chained back-to-back.
        for (int i = 0; i < 200; i++) begin
            op = int'($urandom_range(0, 15));
            if (op == 8) begin
                issue_valid = 1'b0;
                do_mul("rmul", int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                       int'($urandom_range(0, 7)));
            end else begin
                do_single("rnd", op, int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 7)));
            end
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle("rnd.gap");
            end
        end
        idle_cycle("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
